// File: rtl/axi4lite_read_master.sv
// ---------------------------------------------------------------------------
// axi4lite_read_master
//
// AXI4-Lite read initiator. Turns a simple command/response handshake from
// local logic (CPU bridge, DMA, debug port) into single AR/R transactions,
// one outstanding at a time. When CHECK_ALIGN is set, word-misaligned
// addresses are answered locally with SLVERR and never reach the bus. Each
// bus response carries the number of cycles spent in AR+R, saturating at
// 2^LAT_W-1.
//
// Ports:
//   aclk, aresetn        clock (rising edge) / asynchronous active-low reset
//   cmd_valid/ready      command handshake; cmd_addr, cmd_prot payload
//   arvalid/arready      AR channel; araddr, arprot payload
//   rvalid/rready        R channel; rdata, rresp payload
//   rsp_valid/ready      response handshake to local logic
//   rsp_data, rsp_resp   returned data / response code
//   rsp_local            1 = response generated locally (misaligned reject)
//   rsp_latency          cycles spent in AR+R for this transaction
//   busy                 high whenever a command is being processed
// ---------------------------------------------------------------------------
module axi4lite_read_master #(
    parameter int CHECK_ALIGN = 1,
    parameter int LAT_W       = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    // local command side
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [2:0]       cmd_prot,
    // AR channel
    output logic             arvalid,
    input  logic             arready,
    output logic [31:0]      araddr,
    output logic [2:0]       arprot,
    // R channel
    input  logic             rvalid,
    output logic             rready,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    // local response side
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [1:0]       rsp_resp,
    output logic             rsp_local,
    output logic [LAT_W-1:0] rsp_latency,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    localparam logic [LAT_W-1:0] LAT_MAX = '1;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    state_t           state_reg;
    logic [LAT_W-1:0] lat_cnt_reg;

    // Counter value after counting the current cycle, held at LAT_MAX.
    logic [LAT_W-1:0] lat_inc;
    assign lat_inc = (lat_cnt_reg == LAT_MAX) ? LAT_MAX : lat_cnt_reg + LAT_W'(1);

    // Only the low two address bits matter for a 32-bit word alignment check.
    logic misaligned;
    assign misaligned = (CHECK_ALIGN != 0) && (cmd_addr[1:0] != 2'b00);

    assign cmd_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg   <= ST_IDLE;
            lat_cnt_reg <= '0;
            arvalid     <= 1'b0;
            araddr      <= 32'd0;
            arprot      <= 3'd0;
            rready      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 32'd0;
            rsp_resp    <= 2'b00;
            rsp_local   <= 1'b0;
            rsp_latency <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (misaligned) begin
                            rsp_data    <= 32'd0;
                            rsp_resp    <= RESP_SLVERR;
                            rsp_local   <= 1'b1;
                            rsp_latency <= '0;
                            rsp_valid   <= 1'b1;
                            state_reg   <= ST_RSP;
                        end else begin
                            araddr      <= cmd_addr;
                            arprot      <= cmd_prot;
                            arvalid     <= 1'b1;
                            lat_cnt_reg <= '0;
                            state_reg   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    // araddr/arprot are only written in IDLE, so they stay
                    // stable until the handshake.
                    lat_cnt_reg <= lat_inc;
                    if (arready) begin
                        arvalid   <= 1'b0;
                        rready    <= 1'b1;
                        state_reg <= ST_R;
                    end
                end
                ST_R: begin
                    lat_cnt_reg <= lat_inc;
                    if (rvalid) begin
                        rsp_data    <= rdata;
                        rsp_resp    <= rresp;
                        rsp_local   <= 1'b0;
                        rsp_latency <= lat_inc;
                        rready      <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state_reg   <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_read_master.sv
// ---------------------------------------------------------------------------
// tb_axi4lite_read_master
//
// Three instances: 0 = defaults, 1 = CHECK_ALIGN=0, 2 = LAT_W=4. Each has
// its own stimulus. A behavioural slave is driven on the falling edge from
// per-transaction delay settings; expected results are computed from the
// transaction description (local reject rule, delay sum, saturation).
// ---------------------------------------------------------------------------
module tb_axi4lite_read_master;

    localparam int N = 3;

    logic aclk;
    logic aresetn;

    logic [N-1:0]        cmd_valid;
    logic [N-1:0][31:0]  cmd_addr;
    logic [N-1:0][2:0]   cmd_prot;
    logic [N-1:0]        arready;
    logic [N-1:0]        rvalid;
    logic [N-1:0][31:0]  rdata;
    logic [N-1:0][1:0]   rresp;
    logic [N-1:0]        rsp_ready;

    wire  [N-1:0]        cmd_ready;
    wire  [N-1:0]        arvalid;
    wire  [N-1:0][31:0]  araddr;
    wire  [N-1:0][2:0]   arprot;
    wire  [N-1:0]        rready;
    wire  [N-1:0]        rsp_valid;
    wire  [N-1:0][31:0]  rsp_data;
    wire  [N-1:0][1:0]   rsp_resp;
    wire  [N-1:0]        rsp_local;
    wire  [N-1:0][15:0]  rsp_latency;
    wire  [N-1:0]        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            localparam int CA = (gi == 1) ? 0 : 1;
            localparam int LW = (gi == 2) ? 4 : 16;
            logic [LW-1:0] lat_n;
            assign rsp_latency[gi] = 16'(lat_n);
            axi4lite_read_master #(.CHECK_ALIGN(CA), .LAT_W(LW)) dut (
                .aclk       (aclk),
                .aresetn    (aresetn),
                .cmd_valid  (cmd_valid[gi]),
                .cmd_ready  (cmd_ready[gi]),
                .cmd_addr   (cmd_addr[gi]),
                .cmd_prot   (cmd_prot[gi]),
                .arvalid    (arvalid[gi]),
                .arready    (arready[gi]),
                .araddr     (araddr[gi]),
                .arprot     (arprot[gi]),
                .rvalid     (rvalid[gi]),
                .rready     (rready[gi]),
                .rdata      (rdata[gi]),
                .rresp      (rresp[gi]),
                .rsp_valid  (rsp_valid[gi]),
                .rsp_ready  (rsp_ready[gi]),
                .rsp_data   (rsp_data[gi]),
                .rsp_resp   (rsp_resp[gi]),
                .rsp_local  (rsp_local[gi]),
                .rsp_latency(lat_n),
                .busy       (busy[gi])
            );
        end
    endgenerate

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    function automatic int lat_max(input int k);
        return (k == 2) ? 15 : 65535;
    endfunction

    function automatic bit aligns(input int k);
        return (k != 1);
    endfunction

    // Full transaction on instance k, starting and ending on a falling edge.
    task automatic run_txn(input int k, input logic [31:0] addr, input logic [2:0] prot,
                           input int ard, input int rd, input int rspd,
                           input logic [31:0] data, input logic [1:0] resp,
                           input bit early, input string name);
        bit          loc;
        logic [31:0] e_data;
        logic [1:0]  e_resp;
        logic [15:0] e_lat;
        int total, e_busy, e_ar;
        int ar_cyc = 0, rsp_cyc = 0, busy_cyc = 0;
        int ar_cnt = 0, r_cnt = 0, rsp_cnt = 0, guard = 0;
        bit done = 0;

        loc    = aligns(k) && (addr[1:0] != 2'b00);
        total  = ard + rd + 2;
        e_data = loc ? 32'd0 : data;
        e_resp = loc ? 2'b10 : resp;
        e_lat  = loc ? 16'd0 : 16'((total > lat_max(k)) ? lat_max(k) : total);
        e_ar   = loc ? 0 : ard + 1;
        e_busy = loc ? rspd + 1 : total + rspd + 1;

        checks++;
        if (cmd_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s cmd_ready_idle: got %b want 1", name, cmd_ready[k]);
        end
        cmd_valid[k] = 1'b1;
        cmd_addr[k]  = addr;
        cmd_prot[k]  = prot;
        @(negedge aclk);
        cmd_valid[k] = 1'b0;
        cmd_addr[k]  = $urandom;
        cmd_prot[k]  = 3'($urandom);

        checks++;
        if (loc ? (rsp_valid[k] !== 1'b1 || arvalid[k] !== 1'b0) : (arvalid[k] !== 1'b1)) begin
            errors++;
            $display("FAIL %s first_cycle: arvalid=%b rsp_valid=%b local_expected=%0b",
                     name, arvalid[k], rsp_valid[k], loc);
        end

        while (!done && guard < 300) begin
            guard++;
            // sample
            if (busy[k] === 1'b1) busy_cyc++;
            checks++;
            if (cmd_ready[k] !== 1'b0 || busy[k] !== 1'b1) begin
                errors++;
                $display("FAIL %s in_flight: cmd_ready=%b busy=%b want 0/1", name, cmd_ready[k], busy[k]);
            end
            if (arvalid[k] === 1'b1) begin
                ar_cyc++;
                checks++;
                if (araddr[k] !== addr || arprot[k] !== prot) begin
                    errors++;
                    $display("FAIL %s ar_payload: araddr=%h arprot=%b want %h %b",
                             name, araddr[k], arprot[k], addr, prot);
                end
            end
            checks++;
            if (rready[k] === 1'b1 && (arvalid[k] !== 1'b0 || rsp_valid[k] !== 1'b0)) begin
                errors++;
                $display("FAIL %s rready_outside_r: arvalid=%b rsp_valid=%b want 0/0",
                         name, arvalid[k], rsp_valid[k]);
            end
            if (rsp_valid[k] === 1'b1) begin
                rsp_cyc++;
                checks++;
                if (rsp_data[k] !== e_data || rsp_resp[k] !== e_resp ||
                    rsp_local[k] !== loc || rsp_latency[k] !== e_lat) begin
                    errors++;
                    $display("FAIL %s rsp_fields: data=%h resp=%b local=%b lat=%0d want %h %b %b %0d",
                             name, rsp_data[k], rsp_resp[k], rsp_local[k], rsp_latency[k],
                             e_data, e_resp, loc, e_lat);
                end
            end
            // drive slave and response acceptance
            if (arvalid[k] === 1'b1) begin
                ar_cnt++;
                arready[k] = (ar_cnt > ard);
            end else begin
                arready[k] = 1'b0;
            end
            if (rready[k] === 1'b1) begin
                r_cnt++;
                rvalid[k] = (r_cnt > rd);
                rdata[k]  = data;
                rresp[k]  = resp;
            end else if (arvalid[k] === 1'b1 && early) begin
                rvalid[k] = 1'b1;
                rdata[k]  = ~data;
                rresp[k]  = ~resp;
            end else begin
                rvalid[k] = 1'b0;
                rdata[k]  = $urandom;
            end
            if (rsp_valid[k] === 1'b1) begin
                rsp_cnt++;
                rsp_ready[k] = (rsp_cnt > rspd);
                done = rsp_ready[k];
            end else begin
                rsp_ready[k] = 1'b0;
            end
            @(negedge aclk);
        end
        arready[k]   = 1'b0;
        rvalid[k]    = 1'b0;
        rsp_ready[k] = 1'b0;

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: no response after %0d cycles", name, guard);
        end
        checks++;
        if (rsp_valid[k] !== 1'b0 || cmd_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s after_accept: rsp_valid=%b cmd_ready=%b want 0/1", name, rsp_valid[k], cmd_ready[k]);
        end
        checks++;
        if (rsp_data[k] !== e_data || rsp_resp[k] !== e_resp || rsp_local[k] !== loc || rsp_latency[k] !== e_lat) begin
            errors++;
            $display("FAIL %s retain: data=%h resp=%b local=%b lat=%0d want %h %b %b %0d",
                     name, rsp_data[k], rsp_resp[k], rsp_local[k], rsp_latency[k], e_data, e_resp, loc, e_lat);
        end
        checks++;
        if (ar_cyc != e_ar || rsp_cyc != rspd + 1 || busy_cyc != e_busy) begin
            errors++;
            $display("FAIL %s cycle_counts: ar=%0d rsp=%0d busy=%0d want %0d %0d %0d",
                     name, ar_cyc, rsp_cyc, busy_cyc, e_ar, rspd + 1, e_busy);
        end
        $display("txn %s inst=%0d addr=%h local=%0b resp=%b data=%h lat=%0d",
                 name, k, addr, rsp_local[k], rsp_resp[k], rsp_data[k], rsp_latency[k]);
    endtask

    task automatic check_reset_outputs(input int k, input string name);
        checks++;
        if (arvalid[k] !== 1'b0 || araddr[k] !== 32'd0 || arprot[k] !== 3'd0 || rready[k] !== 1'b0 ||
            rsp_valid[k] !== 1'b0 || rsp_data[k] !== 32'd0 || rsp_resp[k] !== 2'b00 ||
            rsp_local[k] !== 1'b0 || rsp_latency[k] !== 16'd0 || cmd_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s inst=%0d: arv=%b ara=%h arp=%b rr=%b rv=%b rd=%h rs=%b rl=%b lat=%0d cr=%b busy=%b want all 0 except cmd_ready=1",
                     name, k, arvalid[k], araddr[k], arprot[k], rready[k], rsp_valid[k], rsp_data[k],
                     rsp_resp[k], rsp_local[k], rsp_latency[k], cmd_ready[k], busy[k]);
        end
    endtask

    task automatic test_reset();
        aresetn   = 1'b0;
        cmd_valid = '0; cmd_addr = '0; cmd_prot = '0;
        arready   = '0; rvalid = '0; rdata = '0; rresp = '0; rsp_ready = '0;
        @(negedge aclk);
        for (int k = 0; k < N; k++) check_reset_outputs(k, "reset_state");
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        $display("txn reset released");
    endtask

    task automatic test_aligned_read();
        run_txn(0, 32'h0000_0010, 3'b000, 0, 0, 0, 32'hDEADBEEF, 2'b00, 0, "aligned");
    endtask

    task automatic test_backpressure();
        run_txn(0, 32'h0000_0100, 3'b101, 3, 4, 5, 32'hA5A5_0F0F, 2'b00, 0, "backpressure");
    endtask

    task automatic test_misaligned();
        run_txn(0, 32'h0000_0013, 3'b010, 2, 2, 1, 32'h1111_2222, 2'b00, 0, "misaligned_check");
        run_txn(1, 32'h0000_0013, 3'b010, 1, 1, 0, 32'h3333_4444, 2'b00, 0, "misaligned_nocheck");
    endtask

    task automatic test_slverr_early_rvalid();
        run_txn(0, 32'h0000_0020, 3'b001, 2, 1, 0, 32'h1234_5678, 2'b10, 1, "slverr_early_rvalid");
        run_txn(0, 32'h0000_0024, 3'b001, 0, 0, 0, 32'h0BAD_F00D, 2'b11, 1, "decerr_passthru");
    endtask

    task automatic test_latency_saturation();
        run_txn(2, 32'h0000_0030, 3'b000, 0, 20, 0, 32'hCAFE_0001, 2'b00, 0, "lat_saturate");
        run_txn(2, 32'h0000_0034, 3'b000, 13, 0, 0, 32'hCAFE_0002, 2'b00, 0, "lat_exact_max");
        run_txn(2, 32'h0000_0038, 3'b000, 2, 3, 0, 32'hCAFE_0003, 2'b01, 0, "lat_small");
    endtask

    task automatic test_back_to_back();
        int t0;
        t0 = cyc;
        for (int i = 0; i < 3; i++)
            run_txn(0, 32'h0000_0040 + 32'(i * 4), 3'b000, 0, 0, 0, $urandom, 2'b00, 0, "b2b_bus");
        checks++;
        if (cyc - t0 != 12) begin
            errors++;
            $display("FAIL b2b_bus_cycles: got %0d want 12", cyc - t0);
        end
        t0 = cyc;
        for (int i = 0; i < 3; i++)
            run_txn(0, 32'h0000_0041 + 32'(i), 3'b000, 0, 0, 0, $urandom, 2'b00, 0, "b2b_local");
        checks++;
        if (cyc - t0 != 6) begin
            errors++;
            $display("FAIL b2b_local_cycles: got %0d want 6", cyc - t0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int k;
            logic [31:0] a;
            k = int'($urandom_range(0, N - 1));
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            run_txn(k, a, 3'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 3)), $urandom, 2'($urandom), bit'($urandom_range(0, 1)),
                    "random");
        end
    endtask

    task automatic test_reset_inflight();
        int guard = 0;
        cmd_valid[0] = 1'b1;
        cmd_addr[0]  = 32'h0000_0050;
        cmd_prot[0]  = 3'b111;
        @(negedge aclk);
        cmd_valid[0] = 1'b0;
        arready[0]   = 1'b1;
        while (rready[0] !== 1'b1 && guard < 20) begin
            guard++;
            @(negedge aclk);
        end
        arready[0] = 1'b0;
        checks++;
        if (rready[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_inflight_reach_r: rready=%b want 1", rready[0]);
        end
        #1 aresetn = 1'b0;
        #1 check_reset_outputs(0, "reset_async");
        @(negedge aclk);
        @(negedge aclk);
        aresetn     = 1'b1;
        rvalid[0]   = 1'b1;
        rdata[0]    = 32'hFFFF_FFFF;
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            checks++;
            if (rsp_valid[0] !== 1'b0 || cmd_ready[0] !== 1'b1 || rready[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_dropped: rsp_valid=%b cmd_ready=%b rready=%b want 0/1/0",
                         rsp_valid[0], cmd_ready[0], rready[0]);
            end
        end
        rvalid[0]    = 1'b0;
        rsp_ready[0] = 1'b0;
        $display("txn reset_inflight dropped");
        run_txn(0, 32'h0000_0060, 3'b011, 1, 1, 1, 32'h5555_AAAA, 2'b00, 0, "after_reset");
    endtask

    initial begin
        aresetn = 1'b0;
        test_reset();
        test_aligned_read();
        test_backpressure();
        test_misaligned();
        test_slverr_early_rvalid();
        test_latency_saturation();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi4lite_read_master.md
Name: axi4lite_read_master

Overview:
- AXI4-Lite read initiator. Converts a simple command/response handshake from local logic (CPU bridge, DMA, debug port) into single AR/R transactions.
- Faces our AXI4-Lite read slaves across the interconnect.
- One outstanding transaction at a time.
- Misaligned addresses are rejected locally without any bus traffic.
- Reports the per-transaction bus latency.

Parameters:
CHECK_ALIGN, 1, 1 = reject cmd_addr[1:0]!=0 locally with SLVERR; 0 = issue every address to the bus unchanged
LAT_W, 16, width of the saturating latency counter / rsp_latency

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_addr  in  32  read byte address
cmd_prot  in  3  AXI protection bits for this command
arvalid  out  1  AR channel valid
arready  in  1  AR channel ready
araddr  out  32  AR address
arprot  out  3  AR protection
rvalid  in  1  R channel valid
rready  out  1  R channel ready
rdata  in  32  R data
rresp  in  2  R response
rsp_valid  out  1  response to local logic valid
rsp_ready  in  1  local logic accepts response
rsp_data  out  32  returned data (0 on local reject)
rsp_resp  out  2  returned response code (OKAY=00, SLVERR=10, others passed through)
rsp_local  out  1  1 = response generated locally (misaligned), no bus access
rsp_latency  out  LAT_W  cycles spent in AR+R for this transaction
busy  out  1  state != IDLE

Behaviour:
- Reset: aresetn (asynchronous, active-low) forces the following; the clock is aclk.
  - state=IDLE.
  - arvalid=0, araddr=0, arprot=0, rready=0.
  - rsp_valid=0, rsp_data=0, rsp_resp=00, rsp_local=0, rsp_latency=0.
  - Latency counter=0.
  - Any in-flight transaction is dropped; no response is produced for it.
- cmd_ready = (state==IDLE), decoded from registered state. busy = ~cmd_ready. All other outputs are registered.
- IDLE:
  - If cmd_valid and CHECK_ALIGN=1 and cmd_addr[1:0]!=0: rsp_data<=0, rsp_resp<=10, rsp_local<=1, rsp_latency<=0, rsp_valid<=1, go to RSP. No AR is issued.
  - Else if cmd_valid: araddr<=cmd_addr, arprot<=cmd_prot, arvalid<=1, counter<=0, go to AR.
- AR:
  - arvalid held high; araddr/arprot held stable until arvalid&arready. arvalid never drops before the handshake.
  - On handshake: arvalid<=0, rready<=1, go to R.
- R:
  - rready high.
  - On rvalid&rready: rsp_data<=rdata, rsp_resp<=rresp, rsp_local<=0, rsp_latency<=counter value including this cycle, rready<=0, rsp_valid<=1, go to RSP.
- RSP:
  - rsp_valid held high; rsp_* held stable until rsp_ready.
  - On rsp_valid&rsp_ready: rsp_valid<=0, go to IDLE.
  - rsp_data/resp/local/latency retain their last values after acceptance.
- Latency counter:
  - Increments by 1 on every cycle spent in AR or R; saturates at 2^LAT_W-1 with no wrap.
  - Minimum reported value is 2: arready high in the first AR cycle and rvalid high in the first R cycle.
- rvalid outside R is ignored (rready=0). arready outside AR is ignored.
- Throughput: minimum 4 cycles per bus transaction (IDLE, AR, R, RSP) with rsp_ready held high. A local reject takes 2 cycles.
- rresp=01/11 is passed through unmodified; no interpretation.
- Address masking: none. araddr = cmd_addr exactly. When CHECK_ALIGN=0, a misaligned address goes to the bus.

Test Plan:
- Aligned read, slave with arready=1 and rvalid one cycle after the AR handshake (rdata=0xDEADBEEF, rresp=00), rsp_ready=1. Required: AR issued with araddr=0x0000_0010; rsp_data=0xDEADBEEF, rsp_resp=00, rsp_local=0, rsp_latency=2, rsp_valid high exactly 1 cycle, busy 3 cycles.
- Backpressure: arready delayed 3 cycles, rvalid delayed 4 cycles, rsp_ready delayed 5 cycles. Required:
  - arvalid/araddr stable throughout AR.
  - rready high only in R.
  - rsp_latency=4+5=9, rsp_* stable while rsp_valid high.
  - cmd_ready low until the rsp handshake.
- Misaligned cmd_addr=0x0000_0013 with CHECK_ALIGN=1. Required: arvalid never asserts; next cycle rsp_valid=1, rsp_resp=10, rsp_data=0, rsp_local=1, rsp_latency=0. Repeat with CHECK_ALIGN=0: AR issued with araddr=0x0000_0013.
- Slave returns rresp=10 with rdata=0x12345678, and rvalid is pulsed while in AR. Required: the early rvalid is ignored; response rsp_resp=10, rsp_data=0x12345678, rsp_local=0.
- LAT_W=4 and rvalid withheld 20 cycles. Required: rsp_latency=15 (saturated), no wrap.
- aresetn asserted while in R (rready=1). Required:
  - All outputs immediately at reset values, asynchronously.
  - After release: state IDLE, cmd_ready=1, no rsp_valid for the dropped transaction.
  - The next command completes normally.
